io_uart_tx: RTL and testbench
=============================

// Module: io_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter on the core's IO store path. Each IO store hands
//  this block a 32-bit word. A data store queues the low byte in a small FIFO.
//  A control store manages the status flags. Queued bytes go out serially as 8N1
//  frames on tx. rd_data is the status word the core reads back on IO loads.
// PARAMETERS
//  CLKS_PER_BIT  434  core clock cycles per UART bit (>=2)
//  FIFO_DEPTH    4    byte FIFO entries (power of two, >=2)
// PORTS
//  clk      in   1   core clock, all logic on posedge
//  rst      in   1   synchronous, active-low reset
//  wr_en    in   1   one-cycle IO store strobe; wr_data is sampled on this edge
//  wr_data  in   32  store data; [31]=0 data write (byte=[7:0]); [31]=1 control write
//  rd_data  out  32  status {28'b0, overflow, empty, full, busy}, registered
//  tx       out  1   UART serial line, idle high
//  busy     out  1   frame in progress OR FIFO non-empty
//  full     out  1   FIFO holds FIFO_DEPTH bytes
// BEHAVIOUR
//  Reset (rst==0 at posedge) clears everything, including mid-frame:
//   tx=1, busy=0, full=0, rd_data=32'h4, overflow=0, FIFO cleared, state=IDLE.
//   The partial frame is abandoned, and tx is high from the next edge.
//  Data write (wr_en & ~wr_data[31]):
//   - if not full: push wr_data[7:0]; the byte is visible in the FIFO one edge later.
//   - if full: drop the byte, set sticky overflow, leave the FIFO unchanged.
//   - push and pop on the same edge while full: accepted, count unchanged, no overflow.
//  Control write (wr_en & wr_data[31]): no push. wr_data[0]=1 clears overflow.
//   Other bits are ignored.
//  FIFO: circular, with read/write pointers and a count 0..FIFO_DEPTH; pointers wrap.
//   full  = (count==FIFO_DEPTH); empty = (count==0).
//  TX FSM: IDLE, START, DATA, STOP. A baud counter runs 0..CLKS_PER_BIT-1.
//   - IDLE: tx=1. On an edge with FIFO non-empty: pop head into shift reg, tx<=0,
//     ->START, baud=0.
//   - START: hold for CLKS_PER_BIT cycles, then tx<=shift[0], ->DATA, bit_idx=0.
//   - DATA: after each CLKS_PER_BIT cycles, shift right and drive the next bit (LSB first).
//     After bit 7's period: tx<=1, ->STOP.
//   - STOP: hold tx=1 for CLKS_PER_BIT cycles. At the end:
//     FIFO non-empty: pop, tx<=0, ->START (back-to-back, no idle gap).
//     FIFO empty: ->IDLE.
//   - A frame is exactly 10*CLKS_PER_BIT cycles. tx is registered (glitch-free).
//  Latency: wr_en sampled at edge E0 into an empty, idle block -> tx falls at E1.
//   The start bit occupies E1..E1+CLKS_PER_BIT-1.
//  busy/full/rd_data: registered, updated every edge from next-state values.
//   No combinational path from wr_en.
//  A pop never happens on an empty FIFO. A write into an empty FIFO can't be popped
//   on the same edge.
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1 Reset: hold rst=0 for 3 edges
//    -> tx=1, busy=0, full=0, rd_data=32'h4.
//  2 Single byte: write 32'h55
//    -> tx is 0,1,0,1,0,1,0,1,0,1, each held 4 cycles, starting 1 cycle after the write.
//    -> busy=0 and rd_data=32'h4 after 40 cycles.
//  3 Back-to-back: write 32'hA5 then 32'h3C on consecutive cycles
//    -> two contiguous 40-cycle frames with no idle gap. LSB-first bits match.
//  4 Overflow: 6 writes (01..06) on consecutive cycles
//    -> the first pop frees one slot, so 01..05 are sent and 06 is dropped.
//    -> rd_data[3]=1 until a write of 32'h8000_0001 clears it. Bytes already queued are unaffected.
//  5 Full + pop: fill the FIFO while the frame engine is mid-frame, then write on the STOP-end pop edge
//    -> the byte is accepted, count stays 4, overflow=0.
//  6 Reset mid-frame: assert rst during DATA bit 3 of 32'hFF00 data
//    -> tx=1 on the next edge, FIFO empty.
//    -> a new write of 32'h81 produces a clean frame.

Source files
------------

// File: rtl/io_uart_tx.sv
// rtl/io_uart_tx.sv - memory-mapped 8N1 UART transmitter with byte FIFO and status word
module io_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        tx,
    output logic        busy,
    output logic        full
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [7:0]    fifo_d [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          busy_q, busy_d;
    logic          full_q, full_d;
    logic [31:0]   rd_data_q, rd_data_d;

    logic          pop;
    logic          push;
    logic          data_wr;
    logic          ctrl_wr;
    logic          fifo_empty;
    logic          fifo_full;
    logic [7:0]    head;

    // Payload bits above the byte field carry no meaning for this block.
    logic          unused_wr_bits;
    assign unused_wr_bits = ^wr_data[30:8];

    assign data_wr    = wr_en & ~wr_data[31];
    assign ctrl_wr    = wr_en &  wr_data[31];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign head       = fifo_q[rd_ptr_q];

    // Frame engine: start bit, 8 data bits LSB first, stop bit; pops the FIFO head
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == BAUD_LAST) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = 3'd0;
                    baud_d    = '0;
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        // Next frame starts immediately so there is no idle gap.
                        pop     = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Byte FIFO and sticky overflow; a pop on the same edge frees the slot for a push
    always_comb begin
        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        push       = data_wr & (~fifo_full | pop);
        if (push) begin
            fifo_d[wr_ptr_q] = wr_data[7:0];
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (data_wr && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
        if (ctrl_wr && wr_data[0]) begin
            overflow_d = 1'b0;
        end
    end

    // Status outputs come from next-state values so they settle with the registers
    always_comb begin
        busy_d    = (state_d != S_IDLE) || (count_d != '0);
        full_d    = (count_d == CNT_FULL);
        rd_data_d = {28'b0, overflow_d, (count_d == '0), full_d, busy_d};
    end

    // Control and status registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
            rd_data_q  <= 32'h0000_0004;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            full_q     <= full_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // FIFO storage; contents are meaningless while count is zero so no reset
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign full    = full_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// tb/tb_io_uart_tx.sv - randomized self-checking bench for io_uart_tx
module tb_io_uart_tx;

    localparam int C = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic [31:0] rd_data;
    logic        tx;
    logic        busy;
    logic        full;

    io_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .tx      (tx),
        .busy    (busy),
        .full    (full)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: queue of pending bytes plus position inside the current frame
    byte unsigned mq[$];
    byte unsigned started[$];
    byte unsigned rx_log[$];
    byte unsigned mcur;
    bit           mactive = 1'b0;
    bit           movf = 1'b0;
    int           mpos = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_tx();
        int p;
        if (!mactive) return 1'b1;
        p = mpos / C;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return mcur[p-1];
    endfunction

    // Model advances on the same edges the DUT samples
    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                mq.delete();
                started.delete();
                mactive = 1'b0;
                mpos    = 0;
                movf    = 1'b0;
            end else begin
                int sz;
                bit ending;
                bit pop;
                byte unsigned b;
                sz     = mq.size();
                ending = mactive && (mpos == 10*C - 1);
                pop    = (sz > 0) && (!mactive || ending);
                b      = 8'h00;
                if (pop) b = mq.pop_front();
                if (wr_en && !wr_data[31]) begin
                    if (sz < D || pop) mq.push_back(wr_data[7:0]);
                    else movf = 1'b1;
                end
                if (wr_en && wr_data[31] && wr_data[0]) movf = 1'b0;
                if (pop) begin
                    mcur    = b;
                    mactive = 1'b1;
                    mpos    = 0;
                    started.push_back(b);
                end else if (ending) begin
                    mactive = 1'b0;
                end else if (mactive) begin
                    mpos++;
                end
            end
        end
    end

    // Per-cycle comparison against the model plus a mid-bit sampling receiver
    bit           rx_busy = 1'b0;
    int           rx_cnt = 0;
    byte unsigned rx_byte = 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("tx",      {31'b0, tx},   {31'b0, model_tx()});
                check("busy",    {31'b0, busy}, {31'b0, (mactive || mq.size() != 0)});
                check("full",    {31'b0, full}, {31'b0, (mq.size() == D)});
                check("rd_data", rd_data, {28'b0, movf, (mq.size() == 0), (mq.size() == D),
                                           (mactive || mq.size() != 0)});
                if (!rst) begin
                    rx_busy = 1'b0;
                end else if (!rx_busy) begin
                    if (tx === 1'b0) begin
                        rx_busy = 1'b1;
                        rx_cnt  = 0;
                        rx_byte = 8'h00;
                    end
                end else begin
                    rx_cnt++;
                    if (rx_cnt < 9*C && rx_cnt >= C + C/2 && ((rx_cnt - C/2) % C) == 0)
                        rx_byte[(rx_cnt - C/2)/C - 1] = tx;
                    if (rx_cnt == 9*C + C/2) begin
                        check("rx_stop", {31'b0, tx}, 32'h1);
                        if (started.size() > 0) check("rx_byte", {24'b0, rx_byte}, {24'b0, started.pop_front()});
                        else check("rx_unexpected", 32'h0, 32'h1);
                        rx_log.push_back(rx_byte);
                        rx_busy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wr(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        wr_data = 32'h0;
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while ((mactive || mq.size() != 0) && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 3000) check(tag, 32'h0, 32'h1);
        @(negedge clk);
        check({tag, "_busy"}, {31'b0, busy}, 32'h0);
        check({tag, "_rd"}, rd_data & 32'h7, 32'h4);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        int sz0;
        int k;
        int r;

        // Reset held for three edges
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx",   {31'b0, tx},   32'h1);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_full", {31'b0, full}, 32'h0);
        check("rst_rd",   rd_data,       32'h4);
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single byte 0x55: alternating line, one-cycle latency
        wr(32'h55);
        @(negedge clk);
        check("t2_latency", {31'b0, tx}, 32'h1);
        pat = 10'b1010101010;
        for (int i = 0; i < 10*C; i++) begin
            @(negedge clk);
            check("t2_bit", {31'b0, tx}, {31'b0, pat[i/C]});
        end
        @(posedge clk);
        #1;
        wait_drain("t2_drain");

        // Back-to-back frames
        sz0 = rx_log.size();
        wr(32'hA5);
        wr(32'h3C);
        wait_drain("t3_drain");
        check("t3_count", rx_log.size() - sz0, 32'd2);
        if (rx_log.size() >= sz0 + 2) begin
            check("t3_b0", {24'b0, rx_log[sz0]},   32'hA5);
            check("t3_b1", {24'b0, rx_log[sz0+1]}, 32'h3C);
        end

        // Overflow: sixth byte dropped, sticky flag until cleared
        sz0 = rx_log.size();
        for (int i = 1; i <= 6; i++) wr(32'(i));
        @(negedge clk);
        check("t4_ovf",  {31'b0, rd_data[3]}, 32'h1);
        check("t4_full", {31'b0, full},       32'h1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t4_ovf_sticky", {31'b0, rd_data[3]}, 32'h1);
        wr(32'h8000_0001);
        @(negedge clk);
        check("t4_ovf_clr", {31'b0, rd_data[3]}, 32'h0);
        @(posedge clk);
        #1;
        wait_drain("t4_drain");
        check("t4_count", rx_log.size() - sz0, 32'd5);
        if (rx_log.size() >= sz0 + 5)
            for (int i = 0; i < 5; i++) check("t4_byte", {24'b0, rx_log[sz0+i]}, 32'(i + 1));

        // Full FIFO plus write on the pop edge at the end of a stop bit
        sz0 = rx_log.size();
        for (int i = 0; i < 5; i++) wr(32'h10 + 32'(i));
        k = 0;
        @(negedge clk);
        while (!(mactive && mpos == 10*C - 1 && mq.size() == D) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("t5_timeout", 32'h0, 32'h1);
        check("t5_full_pre", {31'b0, full}, 32'h1);
        wr_en   = 1'b1;
        wr_data = 32'h15;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        wr_data = 32'h0;
        @(negedge clk);
        check("t5_full_post", {31'b0, full},       32'h1);
        check("t5_no_ovf",    {31'b0, rd_data[3]}, 32'h0);
        @(posedge clk);
        #1;
        wait_drain("t5_drain");
        check("t5_count", rx_log.size() - sz0, 32'd6);
        if (rx_log.size() >= sz0 + 6)
            for (int i = 0; i < 6; i++) check("t5_byte", {24'b0, rx_log[sz0+i]}, 32'h10 + 32'(i));

        // Reset in the middle of data bit 3
        wr(32'hFF00);
        k = 0;
        @(negedge clk);
        while (!(mactive && mpos == 4*C + 1) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("t6_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("t6_tx",   {31'b0, tx},   32'h1);
        check("t6_busy", {31'b0, busy}, 32'h0);
        check("t6_rd",   rd_data,       32'h4);
        @(posedge clk);
        #1;
        sz0 = rx_log.size();
        wr(32'h81);
        wait_drain("t6_drain");
        check("t6_count", rx_log.size() - sz0, 32'd1);
        if (rx_log.size() > sz0) check("t6_byte", {24'b0, rx_log[sz0]}, 32'h81);

        // Random traffic: data writes, control writes, occasional resets
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 999);
            if (r < 3) begin
                rst = 1'b0;
            end else if (r < 90) begin
                wr_en   = 1'b1;
                wr_data = {1'b0, 31'($urandom)};
            end else if (r < 110) begin
                wr_en   = 1'b1;
                wr_data = {1'b1, 31'($urandom)};
            end
            @(posedge clk);
            #1;
            rst     = 1'b1;
            wr_en   = 1'b0;
            wr_data = 32'h0;
        end
        wait_drain("rand_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
